// File: rtl/refcheck_seq_monitor.sv
// Sequences NUM_INSTR back-to-back ILA/RTL refinement-check windows and
// compares observable data at each window end, keeping sticky mismatch/timeout.
module refcheck_seq_monitor #(
    parameter int CNT_W     = 5,
    parameter int MAX_CYCLE = 11,
    parameter int END_CYCLE = 1,
    parameter int USE_READY = 0,
    parameter int NUM_INSTR = 2,
    parameter int DATA_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue_i,
    input  logic              rtl_ready_i,
    input  logic [DATA_W-1:0] ila_data_i,
    input  logic [DATA_W-1:0] rtl_data_i,
    output logic [CNT_W-1:0]  cycle_cnt_o,
    output logic              start_o,
    output logic              started_o,
    output logic              edcond_o,
    output logic              iend_o,
    output logic              ended_o,
    output logic              ended2_o,
    output logic              reseted_o,
    output logic [3:0]        instr_idx_o,
    output logic              mismatch_o,
    output logic              timeout_o,
    output logic              done_o
);

    typedef enum logic [1:0] {ST_START, ST_RUN, ST_GAP, ST_DONE} state_t;

    localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_CYCLE);
    localparam logic [CNT_W-1:0] END_C    = CNT_W'(END_CYCLE);
    localparam logic [3:0]       LAST_IDX = 4'(NUM_INSTR - 1);

    generate
        if ((MAX_CYCLE >= (1 << CNT_W)) || (END_CYCLE < 1) || (END_CYCLE >= MAX_CYCLE) ||
            (NUM_INSTR < 1) || (NUM_INSTR > 16)) begin : g_bad_params
            $error("refcheck_seq_monitor: illegal parameter combination");
        end
    endgenerate

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         idx_q, idx_d;
    logic               start_q, start_d;
    logic               started_q, started_d;
    logic               ended_q, ended_d;
    logic               ended2_q, ended2_d;
    logic               reseted_q;
    logic               mismatch_q, mismatch_d;
    logic               timeout_q, timeout_d;
    logic               done_q, done_d;
    logic               edcond_s;
    logic               iend_s;

    // End condition and first-end detection for the current window
    always_comb begin
        if (USE_READY != 0) begin
            edcond_s = started_q && rtl_ready_i && (cnt_q >= CNT_W'(1));
        end else begin
            edcond_s = started_q && (cnt_q == END_C);
        end
        iend_s = edcond_s && reseted_q && !ended_q;
    end

    // Next-state and next-flag computation
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        start_d    = start_q;
        started_d  = started_q;
        ended_d    = ended_q;
        ended2_d   = ended2_q;
        mismatch_d = mismatch_q;
        timeout_d  = timeout_q;
        done_d     = done_q;
        case (state_q)
            ST_START: begin
                if (issue_i) begin
                    state_d   = ST_RUN;
                    start_d   = 1'b0;
                    started_d = 1'b1;
                    cnt_d     = CNT_W'(1);
                end else begin
                    cnt_d = {CNT_W{1'b0}};
                end
            end
            ST_RUN: begin
                if (cnt_q != MAX_C) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    cnt_d = cnt_q;
                end
                // A real end event outranks a timeout in the same cycle
                if (iend_s) begin
                    ended_d = 1'b1;
                    if (ila_data_i != rtl_data_i) begin
                        mismatch_d = 1'b1;
                    end else begin
                        mismatch_d = mismatch_q;
                    end
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_GAP;
                    end
                end else if (cnt_q == MAX_C) begin
                    timeout_d = 1'b1;
                    state_d   = ST_DONE;
                    done_d    = 1'b1;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_GAP: begin
                idx_d     = idx_q + 4'd1;
                cnt_d     = {CNT_W{1'b0}};
                started_d = 1'b0;
                ended_d   = 1'b0;
                ended2_d  = 1'b0;
                start_d   = 1'b1;
                state_d   = ST_START;
            end
            ST_DONE: begin
                if (edcond_s && ended_q && !ended2_q) begin
                    ended2_d = 1'b1;
                end else begin
                    ended2_d = ended2_q;
                end
            end
            default: begin
                state_d = ST_START;
            end
        endcase
    end

    // State and flag registers; reset overrides everything, even mid-window
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_START;
            cnt_q      <= {CNT_W{1'b0}};
            idx_q      <= 4'd0;
            start_q    <= 1'b1;
            started_q  <= 1'b0;
            ended_q    <= 1'b0;
            ended2_q   <= 1'b0;
            reseted_q  <= 1'b1;
            mismatch_q <= 1'b0;
            timeout_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            start_q    <= start_d;
            started_q  <= started_d;
            ended_q    <= ended_d;
            ended2_q   <= ended2_d;
            reseted_q  <= reseted_q;
            mismatch_q <= mismatch_d;
            timeout_q  <= timeout_d;
            done_q     <= done_d;
        end
    end

    assign cycle_cnt_o = cnt_q;
    assign start_o     = start_q;
    assign started_o   = started_q;
    assign edcond_o    = edcond_s;
    assign iend_o      = iend_s;
    assign ended_o     = ended_q;
    assign ended2_o    = ended2_q;
    assign reseted_o   = reseted_q;
    assign instr_idx_o = idx_q;
    assign mismatch_o  = mismatch_q;
    assign timeout_o   = timeout_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_refcheck_seq_monitor.sv
// Directed bench for refcheck_seq_monitor using three parameterisations
// (default, single window, ready-terminated single window).
module tb_refcheck_seq_monitor;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // instance a: default parameters
    logic       a_issue = 1'b0;
    logic [7:0] a_ila = 8'h00, a_rtl = 8'h00;
    logic [4:0] a_cnt;
    logic [3:0] a_idx;
    logic a_start, a_started, a_edc, a_iend, a_end, a_end2, a_rsd, a_mis, a_to, a_done;

    // instance b: single window
    logic       b_issue = 1'b0;
    logic [7:0] b_ila = 8'h00, b_rtl = 8'h00;
    logic [4:0] b_cnt;
    logic [3:0] b_idx;
    logic b_start, b_started, b_edc, b_iend, b_end, b_end2, b_rsd, b_mis, b_to, b_done;

    // instance c: single window ended by rtl_ready_i
    logic       c_issue = 1'b0, c_rdy = 1'b0;
    logic [7:0] c_ila = 8'h00, c_rtl = 8'h00;
    logic [4:0] c_cnt;
    logic [3:0] c_idx;
    logic c_start, c_started, c_edc, c_iend, c_end, c_end2, c_rsd, c_mis, c_to, c_done;

    refcheck_seq_monitor u_a (
        .clk(clk), .rst_n(rst_n), .issue_i(a_issue), .rtl_ready_i(1'b0),
        .ila_data_i(a_ila), .rtl_data_i(a_rtl), .cycle_cnt_o(a_cnt),
        .start_o(a_start), .started_o(a_started), .edcond_o(a_edc), .iend_o(a_iend),
        .ended_o(a_end), .ended2_o(a_end2), .reseted_o(a_rsd), .instr_idx_o(a_idx),
        .mismatch_o(a_mis), .timeout_o(a_to), .done_o(a_done)
    );

    refcheck_seq_monitor #(.NUM_INSTR(1)) u_b (
        .clk(clk), .rst_n(rst_n), .issue_i(b_issue), .rtl_ready_i(1'b0),
        .ila_data_i(b_ila), .rtl_data_i(b_rtl), .cycle_cnt_o(b_cnt),
        .start_o(b_start), .started_o(b_started), .edcond_o(b_edc), .iend_o(b_iend),
        .ended_o(b_end), .ended2_o(b_end2), .reseted_o(b_rsd), .instr_idx_o(b_idx),
        .mismatch_o(b_mis), .timeout_o(b_to), .done_o(b_done)
    );

    refcheck_seq_monitor #(.USE_READY(1), .NUM_INSTR(1)) u_c (
        .clk(clk), .rst_n(rst_n), .issue_i(c_issue), .rtl_ready_i(c_rdy),
        .ila_data_i(c_ila), .rtl_data_i(c_rtl), .cycle_cnt_o(c_cnt),
        .start_o(c_start), .started_o(c_started), .edcond_o(c_edc), .iend_o(c_iend),
        .ended_o(c_end), .ended2_o(c_end2), .reseted_o(c_rsd), .instr_idx_o(c_idx),
        .mismatch_o(c_mis), .timeout_o(c_to), .done_o(c_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        // ---- scenario A: default parameters, two clean windows ----
        rst_n = 1'b0; a_issue = 1'b1; b_issue = 1'b1; c_issue = 1'b1;
        step();
        chk("a_rst_start", 32'(a_start), 32'd1);
        chk("a_rst_cnt", 32'(a_cnt), 32'd0);
        chk("a_rst_idx", 32'(a_idx), 32'd0);
        chk("a_rst_reseted", 32'(a_rsd), 32'd1);
        chk("a_rst_flags", {26'd0, a_started, a_end, a_end2, a_mis, a_to, a_done}, 32'd0);
        rst_n = 1'b1; a_ila = 8'h3C; a_rtl = 8'h3C;
        step();
        chk("a_w0_started", {30'd0, a_start, a_started}, 32'b01);
        chk("a_w0_iend", {29'd0, a_cnt == 5'd1, a_edc, a_iend}, 32'b111);
        step();
        chk("a_gap_ended", {30'd0, a_end, a_iend}, 32'b10);
        step();
        chk("a_w1_start", {26'd0, a_idx, a_start, a_end}, {26'd0, 4'd1, 1'b1, 1'b0});
        step();
        chk("a_w1_iend", {29'd0, a_cnt == 5'd1, a_iend, a_done}, 32'b110);
        step();
        chk("a_done", {28'd0, a_done, a_mis, a_to, a_end2}, 32'b1000);
        chk("a_done_cnt_idx", {23'd0, a_cnt, a_idx}, {23'd0, 5'd2, 4'd1});
        step();
        chk("a_done_hold", {29'd0, a_done, a_cnt == 5'd2, a_start}, 32'b110);

        // ---- scenario B: single window with data mismatch ----
        rst_n = 1'b0;
        step();
        rst_n = 1'b1; b_ila = 8'hA5; b_rtl = 8'hA4;
        step();
        chk("b_iend", {30'd0, b_iend, b_edc}, 32'b11);
        step();
        chk("b_mismatch", {28'd0, b_mis, b_done, b_end, b_end2}, 32'b1110);
        chk("b_idx_to", {27'd0, b_idx, b_to}, 32'd0);
        step();
        step();
        chk("b_mismatch_hold", {28'd0, b_mis, b_end2, b_edc, b_cnt == 5'd2}, 32'b1001);
        chk("b_rsd_start", {29'd0, b_rsd, b_start, b_started}, 32'b101);

        // ---- scenario C: ready never arrives -> timeout ----
        rst_n = 1'b0; c_rdy = 1'b0; c_ila = 8'h12; c_rtl = 8'h34;
        step();
        rst_n = 1'b1;
        step();
        chk("c_run_cnt1", 32'(c_cnt), 32'd1);
        for (int i = 0; i < 10; i++) step();
        chk("c_cnt_max", {26'd0, c_cnt, c_to}, {26'd0, 5'd11, 1'b0});
        chk("c_not_done", 32'(c_done), 32'd0);
        step();
        chk("c_timeout", {29'd0, c_to, c_done, c_mis}, 32'b110);
        chk("c_sat_cnt", {23'd0, c_cnt, c_idx}, {23'd0, 5'd11, 4'd0});
        step();
        chk("c_sat_hold", {26'd0, c_cnt, c_end}, {26'd0, 5'd11, 1'b0});

        // ---- scenario D: ready exactly at cnt==MAX wins over timeout ----
        rst_n = 1'b0; c_ila = 8'h5A; c_rtl = 8'h5A;
        step();
        rst_n = 1'b1;
        step();
        for (int i = 0; i < 10; i++) begin
            chk("d_no_end", {31'd0, c_edc}, 32'd0);
            step();
        end
        chk("d_cnt_max", 32'(c_cnt), 32'd11);
        c_rdy = 1'b1;
        #1;
        chk("d_iend_at_max", {30'd0, c_edc, c_iend}, 32'b11);
        step();
        chk("d_done_no_to", {28'd0, c_done, c_to, c_end, c_mis}, 32'b1010);
        chk("d_ended2_pending", {30'd0, c_edc, c_end2}, 32'b10);
        step();
        chk("d_ended2", {30'd0, c_end2, c_iend}, 32'b10);
        c_rdy = 1'b0;

        // ---- scenario E: START held while issue_i=0 ----
        rst_n = 1'b0; a_issue = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("e_hold", {24'd0, a_cnt, a_start, a_started, a_done}, {24'd0, 5'd0, 3'b100});
        end
        a_issue = 1'b1; a_ila = 8'h11; a_rtl = 8'h22;
        step();
        chk("e_begin", {24'd0, a_cnt, a_start, a_started, a_iend}, {24'd0, 5'd1, 3'b011});

        // ---- scenario F: reset in window 1 RUN clears everything ----
        step();
        chk("f_mis_set", {30'd0, a_mis, a_end}, 32'b11);
        a_ila = 8'h00; a_rtl = 8'h00;
        step();
        step();
        chk("f_w1_run", {23'd0, a_cnt, a_idx}, {23'd0, 5'd1, 4'd1});
        rst_n = 1'b0;
        step();
        chk("f_rst_vals", {23'd0, a_cnt, a_idx}, 32'd0);
        chk("f_rst_flags", {24'd0, a_start, a_rsd, a_started, a_end, a_end2, a_mis, a_to, a_done},
            32'b11000000);
        rst_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
